// File: rtl/mult_div_sequencer_if.sv
// Handshake bundle between Control, the mult/div sequencer and the mult_div unit.
// The slave side is the sequencer; the master side drives requests and unit status.
interface mult_div_sequencer_if #(
  parameter int CNT_W = 6
);
  logic             start;
  logic             op;
  logic             done;
  logic             div_by0;
  logic             hd_control;
  logic             op_q;
  logic             hi_write;
  logic             lo_write;
  logic             busy;
  logic             finish;
  logic             div0_excp;
  logic             timeout_err;
  logic [CNT_W-1:0] cycles;

  modport master (
    output start, op, done, div_by0,
    input  hd_control, op_q, hi_write, lo_write, busy, finish,
           div0_excp, timeout_err, cycles
  );

  modport slave (
    input  start, op, done, div_by0,
    output hd_control, op_q, hi_write, lo_write, busy, finish,
           div0_excp, timeout_err, cycles
  );
endinterface

// File: rtl/mult_div_sequencer.sv
// Sequences one MULT/DIV through mult_div: start strobe, bounded wait for Done,
// HI/LO commit, and one-cycle divide-by-zero / timeout exception pulses.
module mult_div_sequencer #(
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic                 clock,
  input  logic                 reset,
  mult_div_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_EXCP   = 3'd4,
    ST_TOERR  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic             op_lat_q, op_lat_d;
  logic             hd_control_q, hd_control_d;
  logic             hi_write_q, hi_write_d;
  logic             lo_write_q, lo_write_d;
  logic             busy_q, busy_d;
  logic             finish_q, finish_d;
  logic             div0_excp_q, div0_excp_d;
  logic             timeout_err_q, timeout_err_d;

  // Next-state, counter and latched-op logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cycles_d = cycles_q;
    op_lat_d = op_lat_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d  = ST_LAUNCH;
          op_lat_d = bus.op;
          cnt_d    = {CNT_W{1'b0}};
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // div_by0 only matters for DIV and outranks a simultaneous done.
        if (op_lat_q && bus.div_by0) begin
          state_d = ST_EXCP;
        end else if (bus.done) begin
          state_d = ST_WRITE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = ST_TOERR;
        end else begin
          state_d = ST_WAIT;
        end
        if (state_d != ST_WAIT) begin
          cycles_d = cnt_q + CNT_W'(1);
        end else begin
          cycles_d = cycles_q;
        end
      end
      ST_WRITE, ST_EXCP, ST_TOERR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so every output leaves a flop.
  always_comb begin
    hd_control_d  = 1'b0;
    hi_write_d    = 1'b0;
    lo_write_d    = 1'b0;
    finish_d      = 1'b0;
    div0_excp_d   = 1'b0;
    timeout_err_d = 1'b0;
    busy_d        = (state_d != ST_IDLE);
    case (state_d)
      ST_LAUNCH: hd_control_d = 1'b1;
      ST_WRITE: begin
        hi_write_d = 1'b1;
        lo_write_d = 1'b1;
        finish_d   = 1'b1;
      end
      ST_EXCP: begin
        div0_excp_d = 1'b1;
        finish_d    = 1'b1;
      end
      ST_TOERR: begin
        timeout_err_d = 1'b1;
        finish_d      = 1'b1;
      end
      default: begin
        hd_control_d = 1'b0;
      end
    endcase
  end

  // State, counters and output registers; reset clears everything at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= {CNT_W{1'b0}};
      cycles_q      <= {CNT_W{1'b0}};
      op_lat_q      <= 1'b0;
      hd_control_q  <= 1'b0;
      hi_write_q    <= 1'b0;
      lo_write_q    <= 1'b0;
      busy_q        <= 1'b0;
      finish_q      <= 1'b0;
      div0_excp_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cycles_q      <= cycles_d;
      op_lat_q      <= op_lat_d;
      hd_control_q  <= hd_control_d;
      hi_write_q    <= hi_write_d;
      lo_write_q    <= lo_write_d;
      busy_q        <= busy_d;
      finish_q      <= finish_d;
      div0_excp_q   <= div0_excp_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.hd_control  = hd_control_q;
  assign bus.op_q        = op_lat_q;
  assign bus.hi_write    = hi_write_q;
  assign bus.lo_write    = lo_write_q;
  assign bus.busy        = busy_q;
  assign bus.finish      = finish_q;
  assign bus.div0_excp   = div0_excp_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.cycles      = cycles_q;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Directed bench for mult_div_sequencer: per-cycle vector table plus
// hand-written reset, timeout and reset-mid-WAIT sequences.
module tb_mult_div_sequencer;

  localparam int TIMEOUT = 40;
  localparam int CNT_W   = 6;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  mult_div_sequencer_if #(.CNT_W(CNT_W)) bus_if ();

  mult_div_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // flags: {busy, hd_control, hi_write, lo_write, finish, div0_excp, timeout_err, op_q}
  typedef struct {
    logic             start;
    logic             op;
    logic             done;
    logic             div_by0;
    logic [7:0]       exp_flags;
    logic [CNT_W-1:0] exp_cycles;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [7:0] flags();
    return {bus_if.busy, bus_if.hd_control, bus_if.hi_write, bus_if.lo_write,
            bus_if.finish, bus_if.div0_excp, bus_if.timeout_err, bus_if.op_q};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic s, input logic o, input logic d, input logic z);
    bus_if.start   = s;
    bus_if.op      = o;
    bus_if.done    = d;
    bus_if.div_by0 = z;
  endtask

  task automatic add(input logic s, input logic o, input logic d, input logic z,
                     input logic [7:0] f, input logic [CNT_W-1:0] c);
    vec_t v;
    v.start = s; v.op = o; v.done = d; v.div_by0 = z;
    v.exp_flags = f; v.exp_cycles = c;
    vecs.push_back(v);
  endtask

  initial begin
    int  n;
    bit  saw_write;
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    // MULT, div_by0 high throughout, done on the 5th WAIT edge.
    add(1'b1, 1'b0, 1'b0, 1'b1, 8'b1100_0000, 6'd0);
    for (int i = 0; i < 5; i++) add(1'b0, 1'b0, 1'b0, 1'b1, 8'b1000_0000, 6'd0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 8'b1011_1000, 6'd5);
    add(1'b0, 1'b0, 1'b0, 1'b1, 8'b0000_0000, 6'd5);
    // DIV by zero together with done on the 2nd WAIT edge.
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'b1100_0001, 6'd5);
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'b1000_0001, 6'd5);
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'b1000_0001, 6'd5);
    add(1'b0, 1'b1, 1'b1, 1'b1, 8'b1000_1101, 6'd2);
    add(1'b0, 1'b0, 1'b0, 1'b0, 8'b0000_0001, 6'd2);
    // start held while busy is dropped; op change while busy is ignored.
    add(1'b1, 1'b0, 1'b0, 1'b0, 8'b1100_0000, 6'd2);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'b1000_0000, 6'd2);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'b1000_0000, 6'd2);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'b1000_0000, 6'd2);
    add(1'b1, 1'b1, 1'b1, 1'b0, 8'b1011_1000, 6'd3);
    // start held through finish: one IDLE cycle, then a fresh launch.
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'b0000_0000, 6'd3);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'b1100_0001, 6'd3);
    // done/div_by0 during LAUNCH are ignored; minimum-latency DIV write.
    add(1'b0, 1'b0, 1'b1, 1'b1, 8'b1000_0001, 6'd3);
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'b1011_1001, 6'd1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 8'b0000_0001, 6'd1);

    // Reset held for two cycles.
    tick();
    tick();
    chk("reset_flags", 32'(flags()), 32'd0);
    chk("reset_cycles", 32'(bus_if.cycles), 32'd0);
    reset = 1'b1;
    tick();
    chk("post_reset_busy", 32'(bus_if.busy), 32'd0);

    foreach (vecs[i]) begin
      drive(vecs[i].start, vecs[i].op, vecs[i].done, vecs[i].div_by0);
      tick();
      chk($sformatf("vec%0d_flags", i), 32'(flags()), 32'(vecs[i].exp_flags));
      chk($sformatf("vec%0d_cycles", i), 32'(bus_if.cycles), 32'(vecs[i].exp_cycles));
    end

    // Timeout: DIV with no done and no div_by0.
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("to_launch_hd", 32'(bus_if.hd_control), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    n = 0;
    saw_write = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (bus_if.hi_write || bus_if.lo_write) saw_write = 1'b1;
      if (bus_if.timeout_err) begin
        n = k;
        break;
      end
    end
    chk("to_wait_edges", 32'(n), 32'(TIMEOUT));
    chk("to_finish", 32'(bus_if.finish), 32'd1);
    chk("to_no_write", 32'(saw_write), 32'd0);
    chk("to_cycles", 32'(bus_if.cycles), 32'(TIMEOUT));
    tick();
    chk("to_idle_flags", 32'(flags()), 32'b0000_0001);

    // Reset in the 3rd WAIT cycle, then a late done.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    chk("rmw_busy_before", 32'(bus_if.busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("rmw_async_flags", 32'(flags()), 32'd0);
    chk("rmw_async_cycles", 32'(bus_if.cycles), 32'd0);
    tick();
    tick();
    bus_if.done = 1'b1;
    reset = 1'b1;
    tick();
    chk("rmw_late_done", 32'(flags()), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("rmw_relaunch", 32'(flags()), 32'b1100_0000);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=expired required=finished");
    $fatal(1, "watchdog");
  end

endmodule
